eth_fcs_ctrl: RTL and testbench
===============================

ETH_FCS_CTRL -- requirements
Module: eth_fcs_ctrl

Interface
REQ-001 Parameter MIN_FRAME, default 60, minimum bytes fed to CRC before FCS (payload plus zero padding).
REQ-002 Parameter CRC_LAT, default 1, cycles from last crc_update until crc_value is valid (range 1-15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 s_data  input  8  frame byte from upstream.
REQ-006 s_valid  input  1  s_data valid.
REQ-007 s_last  input  1  marks final payload byte; meaningful only with s_valid.
REQ-008 s_ready  output  1  upstream byte accepted when s_valid&s_ready.
REQ-009 m_data  output  8  byte to MAC transmitter.
REQ-010 m_valid  output  1  m_data valid.
REQ-011 m_last  output  1  final FCS byte.
REQ-012 m_ready  input  1  downstream accept; beat transfers when m_valid&m_ready.
REQ-013 crc_init  output  1  one-cycle pulse restarting CRC accumulator.
REQ-014 crc_update  output  1  CRC engine consumes crc_data this cycle.
REQ-015 crc_data  output  8  byte fed to CRC engine.
REQ-016 crc_value  input  32  finished, reflected, inverted CRC from engine.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 States SHALL be IDLE, DATA, PAD, WAIT, FCS.
REQ-019 IDLE: s_ready=0, m_valid=0; on s_valid=1, crc_init=1 for that cycle, byte counter cleared, next state DATA; no byte consumed in IDLE.
REQ-020 DATA: s_ready=m_ready, m_valid=s_valid, m_data=s_data, m_last=0 (combinational pass-through, zero latency).
REQ-021 DATA: crc_update=s_valid&m_ready, crc_data=s_data; byte counter (11 bit, saturating at 2047) increments per transfer.
REQ-022 DATA, transfer with s_last=1: next state PAD if counter after increment < MIN_FRAME, else WAIT.
REQ-023 PAD: s_ready=0, m_valid=1, m_data=0x00, crc_data=0x00, crc_update=m_ready; counter increments per transfer; transfer that brings counter to MIN_FRAME moves to WAIT.
REQ-024 WAIT: m_valid=0, s_ready=0, crc_update=0; waits exactly CRC_LAT cycles, then registers crc_value into 32-bit fcs register, next state FCS.
REQ-025 FCS: m_valid=1, m_data=fcs byte selected by 2-bit index, LSB first (fcs[7:0], [15:8], [23:16], [31:24]); index advances per transfer.
REQ-026 FCS: m_last=1 only with fcs[31:24]; its transfer returns to IDLE.
REQ-027 m_valid SHALL never drop once raised in PAD or FCS until the beat transfers; m_data stable while m_valid&!m_ready.
REQ-028 crc_update SHALL never assert in IDLE, WAIT or FCS; crc_init only in IDLE.
REQ-029 Frames longer than 2047 bytes SHALL still pass fully; counter saturates, no padding.
REQ-030 Back-to-back frames: at least one IDLE cycle between m_last transfer and next frame's first accepted byte.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, counter=0, fcs=0, index=0, wait counter=0; outputs s_ready, m_valid, m_last, crc_init, crc_update, busy = 0, m_data=crc_data=0.
REQ-032 Reset mid-frame SHALL abandon the frame; after release the next s_valid starts a new frame with crc_init.

Verification
REQ-033 64-byte payload 0x00..0x3F, m_ready=1, CRC_LAT=1 -> 68 output bytes, 64 crc_update pulses, no padding, m_last only on beat 68.
REQ-034 1-byte frame 0xAA with s_last -> 0xAA, 59 x 0x00, 4 FCS bytes (64 total); crc_update pulses 60 times.
REQ-035 crc_value=0xDEADBEEF during WAIT -> FCS bytes 0xEF, 0xBE, 0xAD, 0xDE; m_last with 0xDE.
REQ-036 m_ready toggling every cycle over a 70-byte frame -> output sequence identical to m_ready=1 run; crc_update count 70; no duplicate or lost beat.
REQ-037 rst pulsed while DATA at byte 10 -> all outputs 0 asynchronously; following 60-byte frame yields one crc_init and correct 64-byte output.
REQ-038 Two frames with s_valid held high -> exactly one crc_init per frame, busy low for at least one cycle between frames.

Source files
------------

// File: rtl/eth_fcs_ctrl.sv
// rtl/eth_fcs_ctrl.sv - Ethernet TX framer: payload pass-through, zero padding and FCS append.
module eth_fcs_ctrl #(
    parameter int MIN_FRAME = 60,
    parameter int CRC_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        crc_init,
    output logic        crc_update,
    output logic [7:0]  crc_data,
    input  logic [31:0] crc_value,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, DATA, PAD, WAIT, FCS} state_t;

    localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);
    localparam logic [3:0]  LAT_LAST = 4'(CRC_LAT - 1);

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [31:0] fcs_q, fcs_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  wait_q, wait_d;
    logic [10:0] cnt_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fcs_q   <= '0;
            idx_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fcs_q   <= fcs_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
        end
    end

    // Saturate so oversized frames never wrap back into the padding range.
    assign cnt_inc = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fcs_d      = fcs_q;
        idx_d      = idx_q;
        wait_d     = wait_q;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        m_data     = 8'h00;
        m_last     = 1'b0;
        crc_init   = 1'b0;
        crc_update = 1'b0;
        crc_data   = 8'h00;
        busy       = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    crc_init = 1'b1;
                    cnt_d    = '0;
                    idx_d    = '0;
                    wait_d   = '0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                s_ready    = m_ready;
                m_valid    = s_valid;
                m_data     = s_data;
                crc_update = s_valid & m_ready;
                crc_data   = s_data;
                if (s_valid && m_ready) begin
                    cnt_d = cnt_inc;
                    if (s_last) begin
                        wait_d  = '0;
                        state_d = (cnt_inc < MIN_CNT) ? PAD : WAIT;
                    end
                end
            end
            PAD: begin
                m_valid    = 1'b1;
                crc_update = m_ready;
                if (m_ready) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= MIN_CNT) begin
                        wait_d  = '0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_q == LAT_LAST) begin
                    fcs_d   = crc_value;
                    wait_d  = '0;
                    idx_d   = '0;
                    state_d = FCS;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            FCS: begin
                m_valid = 1'b1;
                case (idx_q)
                    2'd0:    m_data = fcs_q[7:0];
                    2'd1:    m_data = fcs_q[15:8];
                    2'd2:    m_data = fcs_q[23:16];
                    default: m_data = fcs_q[31:24];
                endcase
                m_last = (idx_q == 2'd3);
                if (m_ready) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs go quiet the moment reset asserts, not at the next edge.
        if (rst) begin
            s_ready    = 1'b0;
            m_valid    = 1'b0;
            m_data     = 8'h00;
            m_last     = 1'b0;
            crc_init   = 1'b0;
            crc_update = 1'b0;
            crc_data   = 8'h00;
            busy       = 1'b0;
        end
    end

endmodule

// File: tb/tb_eth_fcs_ctrl.sv
// tb/tb_eth_fcs_ctrl.sv - scoreboard bench for eth_fcs_ctrl.
module tb_eth_fcs_ctrl;
    localparam int MIN_FRAME = 60;
    localparam int CRC_LAT   = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid, s_last, s_ready;
    logic [7:0]  m_data;
    logic        m_valid, m_last, m_ready;
    logic        crc_init, crc_update;
    logic [7:0]  crc_data;
    logic [31:0] crc_value;
    logic        busy;

    eth_fcs_ctrl #(.MIN_FRAME(MIN_FRAME), .CRC_LAT(CRC_LAT)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .crc_init(crc_init), .crc_update(crc_update), .crc_data(crc_data),
        .crc_value(crc_value), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [8:0] exp_q[$];
    logic [7:0] crc_q[$];
    int beats, updates, inits, gap, last_gap;
    bit tracking, hold_pend, toggle;
    logic [7:0] hold_data;

    // Engine stand-in: value is only correct exactly CRC_LAT-1 cycles after the last update.
    logic [31:0] crc_good = 32'h0;
    int lat_cnt = 100;
    always @(posedge clk) begin
        if (crc_update) lat_cnt <= 0;
        else if (lat_cnt < 100) lat_cnt <= lat_cnt + 1;
    end
    assign crc_value = (!crc_update && lat_cnt == CRC_LAT - 1) ? crc_good : 32'h0BAD_F00D;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
            tracking  = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", {31'd0, m_valid}, 32'd1);
                chk("hold_data", {24'd0, m_data}, {24'd0, hold_data});
            end
            hold_pend = m_valid && !m_ready;
            hold_data = m_data;
            if (m_valid && m_ready) begin
                beats++;
                if (exp_q.size() == 0) chk("extra_beat", {24'd0, m_data}, 32'hFFFF_FFFF);
                else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("m_data", {24'd0, m_data}, {24'd0, e[7:0]});
                    chk("m_last", {31'd0, m_last}, {31'd0, e[8]});
                end
                if (m_last) begin
                    tracking = 1'b1;
                    gap = 0;
                end
            end
            if (crc_update) begin
                updates++;
                if (crc_q.size() == 0) chk("extra_update", {24'd0, crc_data}, 32'hFFFF_FFFF);
                else chk("crc_data", {24'd0, crc_data}, {24'd0, crc_q.pop_front()});
            end
            if (crc_init) inits++;
            if (tracking && s_valid && s_ready) begin
                last_gap = gap;
                tracking = 1'b0;
            end
            if (tracking && !busy) gap++;
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = toggle ? ~m_ready : 1'b1;
        end
    end

    task automatic expect_frame(input int n, input logic [7:0] base, input logic [31:0] good);
        logic [31:0] g;
        g = good;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b0, 8'(base + 8'(i))});
            crc_q.push_back(8'(base + 8'(i)));
        end
        for (int i = n; i < MIN_FRAME; i++) begin
            exp_q.push_back(9'h000);
            crc_q.push_back(8'h00);
        end
        exp_q.push_back({1'b0, g[7:0]});
        exp_q.push_back({1'b0, g[15:8]});
        exp_q.push_back({1'b0, g[23:16]});
        exp_q.push_back({1'b1, g[31:24]});
    endtask

    task automatic drive_bytes(input int n, input logic [7:0] base, input bit last, input bit keep);
        bit ok;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(base + 8'(i));
            s_last  = last && (i == n - 1);
            ok = 1'b0;
            for (int t = 0; t < 500; t++) begin
                @(negedge clk);
                if (s_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            @(posedge clk);
            #1;
            if (!ok) begin
                chk("s_ready_timeout", 32'd0, 32'd1);
                break;
            end
        end
        s_last = 1'b0;
        if (!keep) s_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 3000; t++) begin
            if (exp_q.size() == 0 && crc_q.size() == 0) break;
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_out", exp_q.size(), 0);
        chk("drain_crc", crc_q.size(), 0);
    endtask

    task automatic clear_tally();
        beats = 0;
        updates = 0;
        inits = 0;
        last_gap = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, {31'd0, s_ready}, 0);
        chk({tag, "_m_valid"}, {31'd0, m_valid}, 0);
        chk({tag, "_m_last"}, {31'd0, m_last}, 0);
        chk({tag, "_crc_init"}, {31'd0, crc_init}, 0);
        chk({tag, "_crc_update"}, {31'd0, crc_update}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_m_data"}, {24'd0, m_data}, 0);
        chk({tag, "_crc_data"}, {24'd0, crc_data}, 0);
    endtask

    initial begin
        rst = 1'b1;
        s_valid = 1'b1;
        s_data = 8'h5A;
        s_last = 1'b0;
        toggle = 1'b0;
        clear_tally();
        #2;
        check_reset_outputs("por");
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // 64-byte frame, no padding
        clear_tally();
        crc_good = 32'h1234_5678;
        expect_frame(64, 8'h00, crc_good);
        drive_bytes(64, 8'h00, 1'b1, 1'b0);
        drain();
        chk("f64_beats", beats, 68);
        chk("f64_updates", updates, 64);
        chk("f64_inits", inits, 1);

        // 1-byte frame padded out to MIN_FRAME
        clear_tally();
        crc_good = 32'hCAFE_0001;
        expect_frame(1, 8'hAA, crc_good);
        drive_bytes(1, 8'hAA, 1'b1, 1'b0);
        drain();
        chk("f1_beats", beats, 64);
        chk("f1_updates", updates, 60);

        // FCS byte order
        clear_tally();
        crc_good = 32'hDEAD_BEEF;
        expect_frame(60, 8'h20, crc_good);
        drive_bytes(60, 8'h20, 1'b1, 1'b0);
        drain();
        chk("f60_beats", beats, 64);
        chk("f60_updates", updates, 60);

        // backpressure on every other cycle
        clear_tally();
        toggle = 1'b1;
        crc_good = 32'h0F1E_2D3C;
        expect_frame(70, 8'h05, crc_good);
        drive_bytes(70, 8'h05, 1'b1, 1'b0);
        drain();
        toggle = 1'b0;
        chk("f70_beats", beats, 74);
        chk("f70_updates", updates, 70);

        // short frame with backpressure during padding and FCS
        clear_tally();
        toggle = 1'b1;
        crc_good = 32'hA5A5_5A5A;
        expect_frame(7, 8'hF0, crc_good);
        drive_bytes(7, 8'hF0, 1'b1, 1'b0);
        drain();
        toggle = 1'b0;
        chk("f7t_beats", beats, 64);
        chk("f7t_updates", updates, 60);

        // abort at byte 10 with asynchronous reset
        clear_tally();
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({1'b0, 8'(8'h10 + 8'(i))});
            crc_q.push_back(8'(8'h10 + 8'(i)));
        end
        drive_bytes(10, 8'h10, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        chk("abort_beats", beats, 10);
        chk("abort_q", exp_q.size(), 0);
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        clear_tally();
        crc_good = 32'h7777_1111;
        expect_frame(60, 8'h60, crc_good);
        drive_bytes(60, 8'h60, 1'b1, 1'b0);
        drain();
        chk("post_rst_beats", beats, 64);
        chk("post_rst_inits", inits, 1);

        // back-to-back frames with s_valid never dropping
        clear_tally();
        crc_good = 32'h0102_0304;
        expect_frame(20, 8'h40, crc_good);
        expect_frame(65, 8'h80, crc_good);
        drive_bytes(20, 8'h40, 1'b1, 1'b1);
        drive_bytes(65, 8'h80, 1'b1, 1'b0);
        drain();
        chk("b2b_inits", inits, 2);
        chk("b2b_beats", beats, 64 + 69);
        chk("b2b_gap_seen", {31'd0, last_gap >= 1}, 1);

        // oversized frame: counter saturates, no padding
        clear_tally();
        crc_good = 32'h9999_AAAA;
        expect_frame(2100, 8'h00, crc_good);
        drive_bytes(2100, 8'h00, 1'b1, 1'b0);
        drain();
        chk("big_beats", beats, 2104);
        chk("big_updates", updates, 2100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
